if_program_loader: RTL and testbench

- Upstream loader for the instruction-fetch stage. It receives a byte stream from the debug UART receiver and packs it into 32-bit instructions.
- It writes each instruction into instruction memory through the fetch stage's write port (write strobe, instruction, address).
- It detects the HALT word that ends the program, and flags load completion or address overflow to the debug unit, which holds the pipeline disabled while loading is in progress.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_loader_word_packer.sv | 44 ++++
 rtl/if_program_loader.sv | 155 +++++++++++++++
 tb/tb_if_program_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents:
//   state_t        - loader FSM state encoding (3 bits)
//   HALT_WORD      - end-of-program marker
//   BYTES_PER_WORD - UART bytes packed into one instruction
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECEIVE = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/if_loader_word_packer.sv
// Byte-to-word packer for the program loader. Bytes are shifted in
// MSB-first, so the first byte of a word ends up in the top byte lane.
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-low reset
//   i_clear      drop any partial word and restart at byte 0
//   i_shift      accept i_byte this cycle
//   i_byte       incoming byte
//   o_word_next  word as it would be after shifting in i_byte
//   o_word_ready i_byte completes the current word this cycle
module if_loader_word_packer
  import mips_pkg::*;
#(
  parameter int NB_BYTE = 8,
  parameter int NB_INST = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_INST-1:0] o_word_next,
  output logic               o_word_ready
);

  // Only the lower three byte lanes are kept: the top lane is always
  // shifted out by the time a word completes.
  logic [NB_INST-NB_BYTE-1:0] word_lo;
  logic [1:0]                 byte_cnt;

  assign o_word_next  = {word_lo, i_byte};
  assign o_word_ready = i_shift && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      word_lo  <= '0;
      byte_cnt <= 2'd0;
    end else if (i_shift) begin
      word_lo  <= o_word_next[NB_INST-NB_BYTE-1:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/if_program_loader.sv
// Program loader in front of the instruction-fetch write port. Packs the
// debug UART byte stream into instructions, writes them to consecutive
// word addresses and stops on the HALT word (written too) or when the
// memory is full.
// Ports:
//   i_clk          clock
//   i_reset        synchronous active-low reset
//   i_start        pulse: arm / restart a load
//   i_rx_data      received byte
//   i_rx_valid     i_rx_data valid strobe
//   o_write        instruction-memory write strobe (one cycle per word)
//   o_instruction  word being written (holds last written word)
//   o_address      byte address of the word (holds last written address)
//   o_loading      load in progress (RECEIVE / WRITE)
//   o_done         HALT word written
//   o_error        memory filled without a HALT word
//   o_word_count   words written in the current load, HALT included
module if_program_loader
  import mips_pkg::*;
#(
  parameter int                NB_ADDR   = 32,
  parameter int                NB_INST   = 32,
  parameter int                NB_BYTE   = 8,
  parameter int                MEM_DEPTH = 256,
  parameter logic [NB_INST-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [NB_BYTE-1:0]             i_rx_data,
  input  logic                           i_rx_valid,
  output logic                           o_write,
  output logic [NB_INST-1:0]             o_instruction,
  output logic [NB_ADDR-1:0]             o_address,
  output logic                           o_loading,
  output logic                           o_done,
  output logic                           o_error,
  output logic [$clog2(MEM_DEPTH):0]     o_word_count
);

  localparam int WC_W = $clog2(MEM_DEPTH) + 1;

  state_t             state;
  logic [NB_ADDR-1:0] addr;

  logic               pack_shift;
  logic               word_ready;
  logic [NB_INST-1:0] word_next;

  // Decisions taken while in WRITE: o_instruction already holds the word
  // being written, and o_word_count has not yet counted it.
  logic halt_hit;
  logic last_slot;
  logic ends_load;

  assign halt_hit  = (o_instruction == HALT_WORD);
  assign last_slot = (o_word_count == WC_W'(MEM_DEPTH - 1));
  assign ends_load = halt_hit || last_slot;

  // A byte during WRITE starts the next word, unless the load ends there.
  // i_start takes precedence: the byte arriving with it is dropped.
  always_comb begin
    pack_shift = 1'b0;
    if (!i_start && i_rx_valid) begin
      if (state == ST_RECEIVE)
        pack_shift = 1'b1;
      else if (state == ST_WRITE && !ends_load)
        pack_shift = 1'b1;
    end
  end

  if_loader_word_packer #(
    .NB_BYTE (NB_BYTE),
    .NB_INST (NB_INST)
  ) u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_start),
    .i_shift      (pack_shift),
    .i_byte       (i_rx_data),
    .o_word_next  (word_next),
    .o_word_ready (word_ready)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      o_write       <= 1'b0;
      o_instruction <= '0;
      o_address     <= '0;
      o_loading     <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_word_count  <= '0;
    end else begin
      o_write <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            state        <= ST_RECEIVE;
            addr         <= '0;
            o_word_count <= '0;
            o_loading    <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
          end
        end

        ST_RECEIVE: begin
          if (i_start) begin
            addr         <= '0;
            o_word_count <= '0;
          end else if (word_ready) begin
            state         <= ST_WRITE;
            o_write       <= 1'b1;
            o_instruction <= word_next;
            o_address     <= addr;
          end
        end

        ST_WRITE: begin
          if (i_start) begin
            state        <= ST_RECEIVE;
            addr         <= '0;
            o_word_count <= '0;
          end else if (halt_hit) begin
            state        <= ST_DONE;
            o_word_count <= o_word_count + WC_W'(1);
            o_loading    <= 1'b0;
            o_done       <= 1'b1;
          end else begin
            addr         <= addr + NB_ADDR'(BYTES_PER_WORD);
            o_word_count <= o_word_count + WC_W'(1);
            if (last_slot) begin
              state     <= ST_ERROR;
              o_loading <= 1'b0;
              o_error   <= 1'b1;
            end else begin
              state <= ST_RECEIVE;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          o_loading <= 1'b0;
          o_done    <= 1'b0;
          o_error   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_program_loader.sv
// Directed bench for if_program_loader: a cycle-by-cycle vector table for
// a full load plus re-arm, and hand-written sequences for reset, streaming,
// overflow (second instance with MEM_DEPTH = 4) and mid-word restart.
module tb_if_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic        w_a, ld_a, dn_a, er_a;
  logic [31:0] ins_a, adr_a;
  logic [8:0]  wc_a;

  logic        w_b, ld_b, dn_b, er_b;
  logic [31:0] ins_b, adr_b;
  logic [2:0]  wc_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  if_program_loader #(.MEM_DEPTH(256)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_write(w_a), .o_instruction(ins_a), .o_address(adr_a),
    .o_loading(ld_a), .o_done(dn_a), .o_error(er_a), .o_word_count(wc_a)
  );

  if_program_loader #(.MEM_DEPTH(4)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_write(w_b), .o_instruction(ins_b), .o_address(adr_b),
    .o_loading(ld_b), .o_done(dn_b), .o_error(er_b), .o_word_count(wc_b)
  );

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        e_w;
    logic [31:0] e_ins;
    logic [31:0] e_adr;
    logic        e_ld;
    logic        e_dn;
    logic        e_er;
    logic [8:0]  e_wc;
  } vec_t;

  typedef struct {
    logic       st;
    logic       v;
    logic [7:0] d;
  } cyc_t;

  vec_t        vecs[$];
  cyc_t        seq[$];
  logic [31:0] wi_a[$], wa_a[$], wi_b[$], wa_b[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic st, input logic v, input logic [7:0] d,
                         input logic e_w, input logic [31:0] e_ins, input logic [31:0] e_adr,
                         input logic e_ld, input logic e_dn, input logic e_er, input logic [8:0] e_wc);
    vec_t r;
    r.st = st; r.v = v; r.d = d;
    r.e_w = e_w; r.e_ins = e_ins; r.e_adr = e_adr;
    r.e_ld = e_ld; r.e_dn = e_dn; r.e_er = e_er; r.e_wc = e_wc;
    vecs.push_back(r);
  endtask

  task automatic add_cyc(input logic st, input logic v, input logic [7:0] d);
    cyc_t c;
    c.st = st; c.v = v; c.d = d;
    seq.push_back(c);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) add_cyc(1'b0, 1'b1, w[8*k +: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Apply the queued cycles, then 'extra' idle cycles, logging writes.
  task automatic run_seq(input int extra);
    int n;
    wi_a.delete(); wa_a.delete(); wi_b.delete(); wa_b.delete();
    n = seq.size();
    for (int i = 0; i < n + extra; i++) begin
      if (i < n) begin
        start = seq[i].st; rx_valid = seq[i].v; rx_data = seq[i].d;
      end else begin
        start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      end
      @(posedge clk); #1;
      if (w_a) begin wi_a.push_back(ins_a); wa_a.push_back(adr_a); end
      if (w_b) begin wi_b.push_back(ins_b); wa_b.push_back(adr_b); end
    end
    start = 1'b0; rx_valid = 1'b0;
    seq.delete();
  endtask

  task automatic check_wr_a(input string name, input int k, input logic [31:0] e_i, input logic [31:0] e_a);
    if (wi_a.size() > k) check(name, {wi_a[k], wa_a[k]}, {e_i, e_a});
    else check({name, "_missing"}, 128'(wi_a.size()), 128'(k + 1));
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset_state", {w_a, ins_a, adr_a, ld_a, dn_a, er_a, wc_a},
          {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'd0});

    // Reset mid-load: two bytes in, reset, then bytes without i_start
    add_cyc(1'b1, 1'b0, 8'h00);
    add_cyc(1'b0, 1'b1, 8'h12);
    add_cyc(1'b0, 1'b1, 8'h34);
    run_seq(0);
    check("loading_before_reset", 128'(ld_a), 128'(1'b1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset_mid_load", {w_a, ins_a, adr_a, ld_a, dn_a, er_a, wc_a},
          {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'd0});
    add_word(32'h5678_9ABC);
    add_word(32'hFFFF_FFFF);
    run_seq(2);
    check("after_reset_no_writes", 128'(wi_a.size()), 128'(0));
    check("after_reset_idle", {ld_a, dn_a, wc_a}, {1'b0, 1'b0, 9'd0});

    // Table: one word plus HALT, then re-arm from DONE and load again
    do_reset();
    add_vec(1, 0, 8'h00, 0, 32'h0,         32'h0, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h20, 0, 32'h0,         32'h0, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h08, 0, 32'h0,         32'h0, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h00, 0, 32'h0,         32'h0, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h05, 1, 32'h2008_0005, 32'h0, 1, 0, 0, 9'd0);
    add_vec(0, 0, 8'h00, 0, 32'h2008_0005, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 0, 32'h2008_0005, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 0, 32'h2008_0005, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 0, 32'h2008_0005, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 1, 32'hFFFF_FFFF, 32'h4, 1, 0, 0, 9'd1);
    add_vec(0, 0, 8'h00, 0, 32'hFFFF_FFFF, 32'h4, 0, 1, 0, 9'd2);
    add_vec(0, 1, 8'hAA, 0, 32'hFFFF_FFFF, 32'h4, 0, 1, 0, 9'd2);
    add_vec(1, 1, 8'h55, 0, 32'hFFFF_FFFF, 32'h4, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h11, 0, 32'hFFFF_FFFF, 32'h4, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h22, 0, 32'hFFFF_FFFF, 32'h4, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h33, 0, 32'hFFFF_FFFF, 32'h4, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'h44, 1, 32'h1122_3344, 32'h0, 1, 0, 0, 9'd0);
    add_vec(0, 1, 8'hFF, 0, 32'h1122_3344, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 0, 32'h1122_3344, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 0, 32'h1122_3344, 32'h0, 1, 0, 0, 9'd1);
    add_vec(0, 1, 8'hFF, 1, 32'hFFFF_FFFF, 32'h4, 1, 0, 0, 9'd1);
    add_vec(0, 0, 8'h00, 0, 32'hFFFF_FFFF, 32'h4, 0, 1, 0, 9'd2);
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; rx_valid = vecs[i].v; rx_data = vecs[i].d;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            {w_a, ins_a, adr_a, ld_a, dn_a, er_a, wc_a},
            {vecs[i].e_w, vecs[i].e_ins, vecs[i].e_adr, vecs[i].e_ld,
             vecs[i].e_dn, vecs[i].e_er, vecs[i].e_wc});
    end
    start = 1'b0; rx_valid = 1'b0;

    // Back-to-back bytes, including every WRITE cycle
    do_reset();
    add_cyc(1'b1, 1'b0, 8'h00);
    add_word(32'h0102_0304);
    add_word(32'h0506_0708);
    add_word(32'h090A_0B0C);
    add_word(32'hFFFF_FFFF);
    run_seq(3);
    check("b2b_write_count", 128'(wi_a.size()), 128'(4));
    check_wr_a("b2b_w0", 0, 32'h0102_0304, 32'h0);
    check_wr_a("b2b_w1", 1, 32'h0506_0708, 32'h4);
    check_wr_a("b2b_w2", 2, 32'h090A_0B0C, 32'h8);
    check_wr_a("b2b_w3", 3, 32'hFFFF_FFFF, 32'hC);
    check("b2b_done", {dn_a, er_a, ld_a, wc_a}, {1'b1, 1'b0, 1'b0, 9'd4});
    check("b2b_depth4_done", {dn_b, er_b, wc_b}, {1'b1, 1'b0, 3'd4});

    // Overflow on the MEM_DEPTH = 4 instance, then a fifth word
    do_reset();
    add_cyc(1'b1, 1'b0, 8'h00);
    add_word(32'h0101_0101);
    add_word(32'h0202_0202);
    add_word(32'h0303_0303);
    add_word(32'h0404_0404);
    add_word(32'h0505_0505);
    run_seq(3);
    check("ovf_write_count", 128'(wi_b.size()), 128'(4));
    if (wi_b.size() == 4)
      check("ovf_last_write", {wi_b[3], wa_b[3]}, {32'h0404_0404, 32'hC});
    check("ovf_flags", {er_b, ld_b, dn_b, wc_b, adr_b}, {1'b1, 1'b0, 1'b0, 3'd4, 32'hC});
    check("ovf_deep_no_error", {er_a, ld_a, wc_a}, {1'b0, 1'b1, 9'd5});

    // Restart mid-word
    do_reset();
    add_cyc(1'b1, 1'b0, 8'h00);
    add_cyc(1'b0, 1'b1, 8'h12);
    add_cyc(1'b0, 1'b1, 8'h34);
    add_cyc(1'b0, 1'b1, 8'h56);
    add_cyc(1'b1, 1'b0, 8'h00);
    add_word(32'hAABB_CCDD);
    run_seq(2);
    check("restart_write_count", 128'(wi_a.size()), 128'(1));
    check_wr_a("restart_w0", 0, 32'hAABB_CCDD, 32'h0);
    check("restart_state", {ld_a, dn_a, er_a, wc_a}, {1'b1, 1'b0, 1'b0, 9'd1});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
